// File: rtl/cosine_arbiter.sv
// Two-requester round-robin front end for a combinational cosine core.
// Holds one job at a time: grant, let the core settle, present the result.
module cosine_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_angle,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_angle,
    output logic        req1_ready,
    output logic [31:0] core_angle,
    input  logic [31:0] core_result,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_data,
    input  logic        resp_ready,
    output logic        busy,
    output logic [15:0] done_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [31:0] angle_nx;
    logic [31:0] data_nx;
    logic        id_nx;
    logic        last_grant;
    logic        last_nx;
    logic [15:0] done_cnt;
    logic [15:0] done_nx;
    logic        any_req;
    logic        sel;

    assign any_req = req0_valid | req1_valid;

    // On a tie the requester not served last wins; otherwise the lone one.
    assign sel = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign done_count = done_cnt;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        angle_nx   = core_angle;
        data_nx    = resp_data;
        id_nx      = resp_id;
        last_nx    = last_grant;
        done_nx    = done_cnt;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    req0_ready = rst_n & ~sel;
                    req1_ready = rst_n & sel;
                    angle_nx   = sel ? req1_angle : req0_angle;
                    cnt_nx     = CNT_INIT;
                    id_nx      = sel;
                    last_nx    = sel;
                    state_nx   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    data_nx  = core_result;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    done_nx  = done_cnt + 16'd1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            core_angle <= 32'd0;
            resp_data  <= 32'd0;
            resp_id    <= 1'b0;
            last_grant <= 1'b1;
            done_cnt   <= 16'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            core_angle <= angle_nx;
            resp_data  <= data_nx;
            resp_id    <= id_nx;
            last_grant <= last_nx;
            done_cnt   <= done_nx;
        end
    end

endmodule

// File: tb/tb_cosine_arbiter.sv
// Directed bench for cosine_arbiter with a lookup-table cosine core.
// Vector table for single jobs plus hand-written stall/reset/wrap sequences.
module tb_cosine_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_angle, req1_angle;
    logic        req0_ready, req1_ready;
    logic [31:0] core_angle, core_result;
    logic        resp_valid, resp_id, resp_ready, busy;
    logic [31:0] resp_data;
    logic [15:0] done_count;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] exp_count = 16'd0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        id;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[12];

    cosine_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
        .core_angle(core_angle), .core_result(core_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cos_model(input logic [31:0] a);
        case (a)
            32'h0000_0000: cos_model = 32'h3F80_0000;
            32'h3F80_0000: cos_model = 32'h3F0A_5140;
            32'h4000_0000: cos_model = 32'hBED5_1132;
            default:       cos_model = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always_comb core_result = cos_model(core_angle);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge idle.
    task automatic run_job(input logic v0, input logic v1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic eid, input logic [31:0] ed);
        int n;
        req0_valid = v0;
        req1_valid = v1;
        req0_angle = a0;
        req1_angle = a1;
        #1;
        chk("ready0", 32'(req0_ready), 32'(eid == 1'b0));
        chk("ready1", 32'(req1_ready), 32'(eid == 1'b1));
        chk("busy_idle", 32'(busy), 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_angle = 32'hDEAD_0000;
        req1_angle = 32'hDEAD_0001;
        chk("core_angle", core_angle, eid ? a1 : a0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        chk("latency", n, LAT + 1);
        chk("resp_id", 32'(resp_id), 32'(eid));
        chk("resp_data", resp_data, ed);
        chk("count_pre", 32'(done_count), 32'(exp_count));
        @(posedge clk);
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        chk("count_post", 32'(done_count), 32'(exp_count));
        chk("resp_drop", 32'(resp_valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h3F80_0000};
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h4000_0000, 1'b1, 32'hBED5_1132};
        tbl[2]  = '{1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h3F0A_5140};
        tbl[3]  = '{1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBED5_1132};
        tbl[4]  = '{1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h3F0A_5140};
        tbl[5]  = '{1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBED5_1132};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h486E_0C22};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h3F80_0000, 1'b1, 32'h3F0A_5140};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h3F80_0000};
        tbl[9]  = '{1'b1, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0, 32'hBED5_1132};
        tbl[10] = '{1'b1, 1'b0, 32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h3F0A_5140};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h486E_0C22};

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = 32'h1111_1111;
        req1_angle = 32'h2222_2222;
        resp_ready = 1'b1;
        #12;
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_angle", core_angle, 0);
        chk("rst_count", 32'(done_count), 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_job(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].id, tbl[i].data);

        // Consumer stall: response held, no new grant, then pending req1 dropped.
        resp_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = 32'h0000_0000;
        req1_angle = 32'h4000_0000;
        #1;
        chk("stall_grant0", 32'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_angle = 32'h7777_7777;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        chk("stall_latency", n, LAT + 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 1);
            chk("stall_id", 32'(resp_id), 0);
            chk("stall_data", resp_data, 32'h3F80_0000);
            chk("stall_rdy0", 32'(req0_ready), 0);
            chk("stall_rdy1", 32'(req1_ready), 0);
            chk("stall_angle", core_angle, 32'h0000_0000);
            chk("stall_count", 32'(done_count), 32'(exp_count));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        exp_count  = exp_count + 16'd1;
        @(negedge clk);
        chk("after_stall_rdy1", 32'(req1_ready), 1);
        chk("after_stall_rdy0", 32'(req0_ready), 0);
        chk("after_stall_count", 32'(done_count), 32'(exp_count));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drop_busy", 32'(busy), 0);
        end
        resp_ready = 1'b1;

        // Reset mid-SETTLE discards the job.
        req1_valid = 1'b1;
        req1_angle = 32'h4000_0000;
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_id", 32'(resp_id), 0);
        chk("mid_rst_data", resp_data, 0);
        chk("mid_rst_angle", core_angle, 0);
        chk("mid_rst_count", 32'(done_count), 0);
        chk("mid_rst_rdy0", 32'(req0_ready), 0);
        chk("mid_rst_rdy1", 32'(req1_ready), 0);
        exp_count  = 16'd0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_novalid", 32'(resp_valid), 0);
        end
        run_job(1'b1, 1'b1, 32'h3F80_0000, 32'h1234_5678, 1'b0, 32'h3F0A_5140);

        // Counter wrap via back-door preload.
        force dut.done_cnt = 16'hFFFF;
        #1;
        release dut.done_cnt;
        exp_count = 16'hFFFF;
        run_job(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h3F80_0000);
        chk("wrap_zero", 32'(done_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
